// File: rtl/mask_stream_rx_pkg.sv
// Shared widths, defaults and row-index helpers for the mask pattern upload receiver.
package reveal_pkg;

  localparam int MSTREAM_W         = 18;
  localparam int ROW_ADD_W         = 8;
  localparam int DEF_WORDS_PER_ROW = 16;
  localparam int DEF_NUM_ROWS      = 244;

  typedef logic [ROW_ADD_W-1:0] row_idx_t;

  function automatic row_idx_t next_row(input row_idx_t cur, input int num_rows);
    if (cur == row_idx_t'(num_rows - 1)) begin
      next_row = '0;
    end else begin
      next_row = cur + 8'd1;
    end
  endfunction

endpackage

// File: rtl/mask_stream_rx_if.sv
// Link-side words in, assembled rows out; master = link source / row consumer, slave = receiver.
interface mask_stream_rx_if #(
  parameter int WORDS_PER_ROW = reveal_pkg::DEF_WORDS_PER_ROW
);

  logic [reveal_pkg::MSTREAM_W-1:0]               MSTREAM;
  logic                                           EN_STREAM;
  logic                                           CLKMPRE;
  logic [reveal_pkg::MSTREAM_W*WORDS_PER_ROW-1:0] row_data;
  reveal_pkg::row_idx_t                           row_idx;
  logic                                           row_valid;
  logic                                           row_ready;

  modport master (
    output MSTREAM, EN_STREAM, CLKMPRE, row_ready,
    input  row_data, row_idx, row_valid
  );

  modport slave (
    input  MSTREAM, EN_STREAM, CLKMPRE, row_ready,
    output row_data, row_idx, row_valid
  );

endinterface

// File: rtl/mask_stream_rx_slice.sv
// One-entry valid/ready holding register for a completed row and its index.
// A load that finds the entry occupied and not being drained is dropped and flagged.
module mask_row_slice
  import reveal_pkg::*;
#(
  parameter int DATA_W = MSTREAM_W * DEF_WORDS_PER_ROW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  row_idx_t          idx_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output row_idx_t          idx_o,
  output logic              drop_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  row_idx_t          idx_q, idx_d;
  logic              take_s;

  // Accept + load in the same cycle refills without a bubble.
  assign take_s = load_i & (~valid_q | ready_i);
  assign drop_o = load_i & ~take_s;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    if (take_s) begin
      valid_d = 1'b1;
      data_d  = data_i;
      idx_d   = idx_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign idx_o   = idx_q;

endmodule

// File: rtl/mask_stream_rx.sv
// Mask pattern upload receiver: assembles 18-bit link words into indexed rows.
// Optional frame XOR signature outputs are built when MASK_SIG_EN is defined.
module mask_stream_rx
  import reveal_pkg::*;
#(
  parameter int WORDS_PER_ROW = DEF_WORDS_PER_ROW,
  parameter int NUM_ROWS      = DEF_NUM_ROWS
) (
  input  logic                 CLKM,
  input  logic                 RST,
  mask_stream_rx_if.slave      bus,
  output logic                 frame_done,
  output logic                 err_short,
  output logic                 err_long,
  output logic                 err_ovr,
  input  logic                 err_clr
`ifdef MASK_SIG_EN
  ,
  output logic [MSTREAM_W-1:0] frame_sig,
  output logic                 frame_sig_valid
`endif
);

  localparam int ROW_W  = MSTREAM_W * WORDS_PER_ROW;
  localparam int CNT_W  = $clog2(WORDS_PER_ROW + 1);
  localparam int SLOT_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(WORDS_PER_ROW);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(WORDS_PER_ROW - 1);

  logic              pre_q;
  logic              start_s, cnt_full_s, wr_en_s, row_last_s, drop_s;
  logic              short_set_s, long_set_s;
  logic [SLOT_W-1:0] slot_s;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [ROW_W-1:0]  row_buf_q, row_buf_d;
  logic              row_done_q, row_done_d;
  row_idx_t          row_cnt_q, row_cnt_d;
  logic              frame_done_q, frame_done_d;
  logic              err_short_q, err_short_d;
  logic              err_long_q, err_long_d;
  logic              err_ovr_q, err_ovr_d;

  // A word arriving with the row marker always lands in slot 0 of the new row.
  assign start_s     = bus.CLKMPRE & ~pre_q;
  assign cnt_full_s  = (word_cnt_q == CNT_FULL);
  assign wr_en_s     = bus.EN_STREAM & (start_s | ~cnt_full_s);
  assign slot_s      = start_s ? '0 : word_cnt_q[SLOT_W-1:0];
  assign row_last_s  = (row_cnt_q == row_idx_t'(NUM_ROWS - 1));
  assign short_set_s = start_s & (word_cnt_q != '0) & ~cnt_full_s;
  assign long_set_s  = bus.EN_STREAM & ~start_s & cnt_full_s;

  always_comb begin
    word_cnt_d = word_cnt_q;
    row_buf_d  = row_buf_q;
    row_done_d = 1'b0;
    if (wr_en_s) begin
      row_buf_d[slot_s*MSTREAM_W +: MSTREAM_W] = bus.MSTREAM;
      word_cnt_d = CNT_W'(slot_s) + CNT_W'(1);
      row_done_d = (slot_s == SLOT_LAST);
    end else if (start_s) begin
      word_cnt_d = '0;
    end else begin
      word_cnt_d = word_cnt_q;
    end
  end

  // Row index follows the link even when the consumer drops rows.
  always_comb begin
    row_cnt_d    = row_cnt_q;
    frame_done_d = 1'b0;
    if (row_done_q) begin
      row_cnt_d    = next_row(row_cnt_q, NUM_ROWS);
      frame_done_d = row_last_s;
    end else begin
      row_cnt_d    = row_cnt_q;
    end
  end

  assign err_short_d = short_set_s | (err_short_q & ~err_clr);
  assign err_long_d  = long_set_s  | (err_long_q  & ~err_clr);
  assign err_ovr_d   = drop_s      | (err_ovr_q   & ~err_clr);

  always_ff @(posedge CLKM) begin
    if (RST) begin
      pre_q        <= 1'b1;
      word_cnt_q   <= '0;
      row_buf_q    <= '0;
      row_done_q   <= 1'b0;
      row_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
      err_ovr_q    <= 1'b0;
    end else begin
      pre_q        <= bus.CLKMPRE;
      word_cnt_q   <= word_cnt_d;
      row_buf_q    <= row_buf_d;
      row_done_q   <= row_done_d;
      row_cnt_q    <= row_cnt_d;
      frame_done_q <= frame_done_d;
      err_short_q  <= err_short_d;
      err_long_q   <= err_long_d;
      err_ovr_q    <= err_ovr_d;
    end
  end

  mask_row_slice #(
    .DATA_W (ROW_W)
  ) u_slice (
    .clk_i   (CLKM),
    .rst_i   (RST),
    .load_i  (row_done_q),
    .data_i  (row_buf_q),
    .idx_i   (row_cnt_q),
    .ready_i (bus.row_ready),
    .valid_o (bus.row_valid),
    .data_o  (bus.row_data),
    .idx_o   (bus.row_idx),
    .drop_o  (drop_s)
  );

  assign frame_done = frame_done_q;
  assign err_short  = err_short_q;
  assign err_long   = err_long_q;
  assign err_ovr    = err_ovr_q;

`ifdef MASK_SIG_EN
  // Per-row partial signature is folded in only once the row completes, so short rows never count.
  logic [MSTREAM_W-1:0] row_sig_q, row_sig_d;
  logic [MSTREAM_W-1:0] frame_acc_q, frame_acc_d;
  logic [MSTREAM_W-1:0] frame_sig_q, frame_sig_d;
  logic [MSTREAM_W-1:0] frame_full_s;
  logic                 frame_sig_valid_q, frame_sig_valid_d;

  assign frame_full_s = frame_acc_q ^ row_sig_q;

  always_comb begin
    row_sig_d         = row_sig_q;
    frame_acc_d       = frame_acc_q;
    frame_sig_d       = frame_sig_q;
    frame_sig_valid_d = 1'b0;
    if (start_s) begin
      row_sig_d = bus.EN_STREAM ? bus.MSTREAM : '0;
    end else if (wr_en_s) begin
      row_sig_d = row_sig_q ^ bus.MSTREAM;
    end else begin
      row_sig_d = row_sig_q;
    end
    if (row_done_q) begin
      if (row_last_s) begin
        frame_sig_d       = frame_full_s;
        frame_sig_valid_d = 1'b1;
        frame_acc_d       = '0;
      end else begin
        frame_acc_d       = frame_full_s;
      end
    end else begin
      frame_acc_d = frame_acc_q;
    end
  end

  always_ff @(posedge CLKM) begin
    if (RST) begin
      row_sig_q         <= '0;
      frame_acc_q       <= '0;
      frame_sig_q       <= '0;
      frame_sig_valid_q <= 1'b0;
    end else begin
      row_sig_q         <= row_sig_d;
      frame_acc_q       <= frame_acc_d;
      frame_sig_q       <= frame_sig_d;
      frame_sig_valid_q <= frame_sig_valid_d;
    end
  end

  assign frame_sig       = frame_sig_q;
  assign frame_sig_valid = frame_sig_valid_q;
`endif

endmodule

// File: tb/tb_mask_stream_rx.sv
// Directed bench for mask_stream_rx (WORDS_PER_ROW=16, NUM_ROWS=4); signature steps need MASK_SIG_EN.
module tb_mask_stream_rx;
  import reveal_pkg::*;

  localparam int WPR = 16;
  localparam int NR  = 4;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic err_clr = 1'b0;
  logic frame_done, err_short, err_long, err_ovr;
`ifdef MASK_SIG_EN
  logic [17:0] frame_sig;
  logic        frame_sig_valid;
`endif

  int checks = 0;
  int errors = 0;

  mask_stream_rx_if #(.WORDS_PER_ROW(WPR)) bus ();

  mask_stream_rx #(
    .WORDS_PER_ROW (WPR),
    .NUM_ROWS      (NR)
  ) dut (
    .CLKM            (clk),
    .RST             (rst),
    .bus             (bus),
    .frame_done      (frame_done),
    .err_short       (err_short),
    .err_long        (err_long),
    .err_ovr         (err_ovr),
    .err_clr         (err_clr)
`ifdef MASK_SIG_EN
    ,
    .frame_sig       (frame_sig),
    .frame_sig_valid (frame_sig_valid)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic pre, input logic en, input logic [17:0] d);
    bus.CLKMPRE   = pre;
    bus.EN_STREAM = en;
    bus.MSTREAM   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 18'h0);
  endtask

  task automatic send_row(input logic [17:0] base);
    for (int k = 0; k < WPR; k++) cyc(k == 0, 1'b1, base + 18'(k));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    err_clr = 1'b0;
    bus.row_ready = 1'b0;
    idle();
    idle();
    rst = 1'b0;
    idle();
  endtask

  function automatic logic [17:0] word(input int k);
    word = bus.row_data[k*18 +: 18];
  endfunction

  initial begin
    bus.CLKMPRE = 1'b0;
    bus.EN_STREAM = 1'b0;
    bus.MSTREAM = 18'h0;
    bus.row_ready = 1'b0;

    // Reset state
    do_reset();
    check("rst_valid", bus.row_valid, 1'b0);
    check("rst_idx", bus.row_idx, 8'd0);
    check("rst_data", bus.row_data[31:0], 32'h0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_errs", {err_short, err_long, err_ovr}, 3'b000);
`ifdef MASK_SIG_EN
    check("rst_sig", {frame_sig_valid, frame_sig}, 19'h0);
`endif

    // Nominal row 0x00001..0x00010
    send_row(18'h00001);
    check("nom_not_yet", bus.row_valid, 1'b0);
    idle();
    check("nom_valid", bus.row_valid, 1'b1);
    check("nom_idx", bus.row_idx, 8'd0);
    check("nom_w0", word(0), 18'h00001);
    check("nom_w15", word(15), 18'h00010);
    bus.row_ready = 1'b1;
    idle();
    check("nom_accepted", bus.row_valid, 1'b0);

    // Short row: 10 words then a new row marker
    do_reset();
    for (int k = 0; k < 10; k++) cyc(k == 0, 1'b1, 18'h00050 + 18'(k));
    cyc(1'b1, 1'b0, 18'h0);
    check("short_err", err_short, 1'b1);
    check("short_no_row", bus.row_valid, 1'b0);
    idle();
    send_row(18'h00020);
    idle();
    check("short_next_valid", bus.row_valid, 1'b1);
    check("short_next_idx", bus.row_idx, 8'd0);
    check("short_next_w0", word(0), 18'h00020);
    err_clr = 1'b1;
    idle();
    err_clr = 1'b0;
    check("short_clr", err_short, 1'b0);

    // Long row: 17 words in one period
    do_reset();
    send_row(18'h00030);
    cyc(1'b0, 1'b1, 18'h3AAAA);
    check("long_valid", bus.row_valid, 1'b1);
    check("long_err", err_long, 1'b1);
    check("long_w15", word(15), 18'h0003F);
    check("long_idx", bus.row_idx, 8'd0);
    bus.row_ready = 1'b1;
    idle();
    check("long_taken", bus.row_valid, 1'b0);
    idle();
    check("long_once", bus.row_valid, 1'b0);

    // Backpressure across two rows
    do_reset();
    send_row(18'h00100);
    send_row(18'h00200);
    idle();
    idle();
    check("bp_held_valid", bus.row_valid, 1'b1);
    check("bp_held_idx", bus.row_idx, 8'd0);
    check("bp_held_w0", word(0), 18'h00100);
    check("bp_held_w15", word(15), 18'h0010F);
    check("bp_ovr", err_ovr, 1'b1);
    bus.row_ready = 1'b1;
    idle();
    check("bp_drained", bus.row_valid, 1'b0);
    send_row(18'h00300);
    idle();
    check("bp_next_idx", bus.row_idx, 8'd2);
    check("bp_next_w0", word(0), 18'h00300);

    // Row index wrap with NUM_ROWS=4
    do_reset();
    bus.row_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      send_row(18'(r * 64));
      idle();
      check("wrap_valid", bus.row_valid, 1'b1);
      check("wrap_idx", bus.row_idx, 32'(r % NR));
      check("wrap_frame_done", frame_done, (r == 3) ? 1'b1 : 1'b0);
    end
    idle();
    check("wrap_fd_clear", frame_done, 1'b0);

`ifdef MASK_SIG_EN
    // Frame signature: one odd word, then an all-ones frame
    do_reset();
    bus.row_ready = 1'b1;
    for (int r = 0; r < NR; r++) begin
      for (int k = 0; k < WPR; k++)
        cyc(k == 0, 1'b1, (r == 2 && k == 5) ? 18'h00001 : 18'h3FFFF);
      idle();
    end
    check("sig1_valid", frame_sig_valid, 1'b1);
    check("sig1_value", frame_sig, 18'h3FFFE);
    idle();
    check("sig1_pulse", frame_sig_valid, 1'b0);
    check("sig1_hold", frame_sig, 18'h3FFFE);
    for (int r = 0; r < NR; r++) begin
      for (int k = 0; k < WPR; k++) cyc(k == 0, 1'b1, 18'h3FFFF);
      idle();
    end
    check("sig2_valid", frame_sig_valid, 1'b1);
    check("sig2_value", frame_sig, 18'h00000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
